// File: rtl/sound_effect_sequencer.sv
// Sound-effect sequencer: takes shoot/explosion play commands over Avalon-MM,
// arbitrates them and drives the tone generator's start/select pair.
module sound_effect_sequencer #(
    parameter int SHOOT_LEN   = 8105,
    parameter int EXPLODE_LEN = 3044,
    parameter int CNT_W       = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        sample_taken,
    output logic        start_audio,
    output logic        selected_audio,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SHOOT_LEN_C   = CNT_W'(SHOOT_LEN);
    localparam logic [CNT_W-1:0] EXPLODE_LEN_C = CNT_W'(EXPLODE_LEN);
    localparam logic [CNT_W-1:0] ONE_C         = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_pend_shoot;
    logic               r_pend_explode;
    logic               r_sel;
    logic [15:0]        r_readdata;

    logic [CNT_W-1:0]   w_len;
    logic               w_cmd_wr;
    logic               w_req_shoot;
    logic               w_req_explode;
    logic               w_last;
    logic               w_take_shoot;
    logic               w_take_explode;
    logic               w_unused;

    assign w_len         = r_sel ? EXPLODE_LEN_C : SHOOT_LEN_C;
    assign w_cmd_wr      = chipselect & write & (address == 2'd0);
    assign w_req_shoot   = w_cmd_wr & writedata[0];
    assign w_req_explode = w_cmd_wr & writedata[1];
    // The sample accepted this cycle is the effect's final one.
    assign w_last        = sample_taken & (r_count == (w_len - ONE_C));
    assign w_unused      = &{1'b0, writedata[15:2]};

    // Explosion always outranks shoot; a shoot request only restarts a shoot.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state   = r_state;
        w_take_shoot   = 1'b0;
        w_take_explode = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_explode) begin
                    w_take_explode = 1'b1;
                    w_next_state   = GAP;
                end else if (r_pend_shoot) begin
                    w_take_shoot = 1'b1;
                    w_next_state = GAP;
                end
            end
            GAP: begin
                w_next_state = PLAY;
            end
            PLAY: begin
                if (r_pend_explode) begin
                    w_take_explode = 1'b1;
                    w_next_state   = GAP;
                end else if (r_pend_shoot && !r_sel) begin
                    w_take_shoot = 1'b1;
                    w_next_state = GAP;
                end else if (w_last) begin
                    if (r_pend_shoot) begin
                        w_take_shoot = 1'b1;
                        w_next_state = GAP;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_next_state;
        end
    end

    // Selection only moves on entry to GAP, so it is stable throughout PLAY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel          <= 1'b0;
            r_pend_shoot   <= 1'b0;
            r_pend_explode <= 1'b0;
        end else begin
            if (w_take_explode) begin
                r_sel <= 1'b1;
            end else if (w_take_shoot) begin
                r_sel <= 1'b0;
            end
            r_pend_shoot   <= (r_pend_shoot & ~w_take_shoot) | w_req_shoot;
            r_pend_explode <= (r_pend_explode & ~w_take_explode) | w_req_explode;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state == GAP) begin
            r_count <= '0;
        end else if ((r_state == PLAY) && sample_taken && (r_count != w_len)) begin
            r_count <= r_count + ONE_C;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (chipselect & read) begin
            case (address)
                2'd0:    r_readdata <= {13'b0, r_pend_shoot, r_sel, (r_state == PLAY)};
                2'd1:    r_readdata <= 16'(r_count);
                2'd2:    r_readdata <= 16'(w_len);
                default: r_readdata <= '0;
            endcase
        end
    end

    // start_audio is decoded straight from the state so reset drops it at once.
    assign start_audio    = (r_state == PLAY);
    assign selected_audio = r_sel;
    assign busy           = (r_state != IDLE) | r_pend_shoot | r_pend_explode;
    assign readdata       = r_readdata;

endmodule

// File: tb/tb_sound_effect_sequencer.sv
// Self-checking bench for sound_effect_sequencer: directed scenarios plus
// randomized traffic against a behavioural model of the effect sequencing.
module tb_sound_effect_sequencer;

    localparam int SHOOT_LEN   = 8105;
    localparam int EXPLODE_LEN = 3044;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [15:0] writedata = 16'd0;
    logic        sample_taken = 1'b0;
    logic [15:0] readdata;
    logic        start_audio;
    logic        selected_audio;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sound_effect_sequencer #(
        .SHOOT_LEN  (SHOOT_LEN),
        .EXPLODE_LEN(EXPLODE_LEN),
        .CNT_W      (14)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .read          (read),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .sample_taken  (sample_taken),
        .start_audio   (start_audio),
        .selected_audio(selected_audio),
        .busy          (busy)
    );

    // Behavioural model: what is playing, whether a silent gap is due,
    // the samples consumed so far and the two pending requests.
    bit          m_gap;
    bit          m_play;
    bit          m_sel;
    bit          m_ps;
    bit          m_pe;
    int          m_count;
    logic [15:0] m_rd;

    function automatic int eff_len(input bit sel);
        return sel ? EXPLODE_LEN : SHOOT_LEN;
    endfunction

    function automatic bit m_busy();
        return m_gap | m_play | m_ps | m_pe;
    endfunction

    task automatic model_reset();
        m_gap = 0; m_play = 0; m_sel = 0; m_ps = 0; m_pe = 0;
        m_count = 0; m_rd = 16'd0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit req_s, req_e, take_s, take_e, finished;
        req_s  = chipselect && write && (address == 2'd0) && writedata[0];
        req_e  = chipselect && write && (address == 2'd0) && writedata[1];
        take_s = 0;
        take_e = 0;
        if (chipselect && read) begin
            case (address)
                2'd0:    m_rd = {13'd0, m_ps, m_sel, m_play};
                2'd1:    m_rd = 16'(m_count);
                2'd2:    m_rd = 16'(eff_len(m_sel));
                default: m_rd = 16'd0;
            endcase
        end
        if (m_gap) begin
            m_gap   = 0;
            m_play  = 1;
            m_count = 0;
        end else if (m_play) begin
            if (sample_taken && m_count < eff_len(m_sel)) m_count++;
            finished = (m_count == eff_len(m_sel));
            if (m_pe) take_e = 1;
            else if (m_ps && !m_sel) take_s = 1;
            else if (finished) begin
                if (m_ps) take_s = 1;
                else m_play = 0;
            end
            if (take_e || take_s) begin
                m_play = 0;
                m_gap  = 1;
                m_sel  = take_e;
            end
        end else begin
            if (m_pe) take_e = 1;
            else if (m_ps) take_s = 1;
            if (take_e || take_s) begin
                m_gap = 1;
                m_sel = take_e;
            end
        end
        m_pe = (m_pe && !take_e) || req_e;
        m_ps = (m_ps && !take_s) || req_s;
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cycle(input bit cs, input bit wr, input bit rd,
                         input logic [1:0] a, input logic [15:0] wd, input bit st);
        chipselect   = cs;
        write        = wr;
        read         = rd;
        address      = a;
        writedata    = wd;
        sample_taken = st;
        if (reset) model_step();
        @(posedge clk);
        #1;
        chipselect   = 1'b0;
        write        = 1'b0;
        read         = 1'b0;
        address      = 2'd0;
        writedata    = 16'd0;
        sample_taken = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    endtask

    task automatic cmd(input logic [15:0] wd);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, wd, 1'b0);
    endtask

    task automatic do_read(input logic [1:0] a);
        cycle(1'b1, 1'b0, 1'b1, a, 16'd0, 1'b0);
    endtask

    // Issue n sample pulses with occasional idle gaps; counts cycles where
    // the DUT outputs disagree with the model.
    task automatic pulses(input int n, output int diverged);
        diverged = 0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g <= gap; g++) begin
                cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, (g == gap));
                if ({start_audio, selected_audio, busy} !== {m_play, m_sel, m_busy()}) diverged++;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        n_checks++;
        if ({readdata, start_audio, selected_audio, busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rd=%h start=%b sel=%b busy=%b expected all 0",
                     readdata, start_audio, selected_audio, busy);
        end
        do_read(2'd0);
        n_checks++;
        if (readdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_read0: got %h expected 0000", readdata);
        end
    endtask

    task automatic test_shoot_full();
        int div;
        cmd(16'h0001);
        n_checks++;
        if ({start_audio, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL shoot_pending: got start=%b busy=%b expected 0 1", start_audio, busy);
        end
        idle(1);
        n_checks++;
        if (start_audio !== 1'b0) begin
            n_fail++;
            $display("FAIL shoot_gap: got start=%b expected 0", start_audio);
        end
        idle(1);
        n_checks++;
        if ({start_audio, selected_audio} !== 2'b10) begin
            n_fail++;
            $display("FAIL shoot_rise: got start=%b sel=%b expected 1 0", start_audio, selected_audio);
        end
        pulses(SHOOT_LEN - 1, div);
        n_checks++;
        if (start_audio !== 1'b1) begin
            n_fail++;
            $display("FAIL shoot_hold: got start=%b expected 1 before last sample", start_audio);
        end
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL shoot_end: got start=%b busy=%b expected 0 0", start_audio, busy);
        end
        n_checks++;
        if (div !== 0) begin
            n_fail++;
            $display("FAIL shoot_track: got %0d divergent cycles expected 0", div);
        end
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'(SHOOT_LEN)) begin
            n_fail++;
            $display("FAIL shoot_count: got %0d expected %0d", readdata, SHOOT_LEN);
        end
    endtask

    task automatic test_preempt();
        int div;
        cmd(16'h0001);
        idle(2);
        pulses(100, div);
        cmd(16'h0002);
        n_checks++;
        if (start_audio !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_n1: got start=%b expected 1", start_audio);
        end
        idle(1);
        n_checks++;
        if ({start_audio, selected_audio} !== 2'b01) begin
            n_fail++;
            $display("FAIL preempt_gap: got start=%b sel=%b expected 0 1", start_audio, selected_audio);
        end
        idle(1);
        n_checks++;
        if ({start_audio, selected_audio} !== 2'b11) begin
            n_fail++;
            $display("FAIL preempt_play: got start=%b sel=%b expected 1 1", start_audio, selected_audio);
        end
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'd0) begin
            n_fail++;
            $display("FAIL preempt_count: got %0d expected 0", readdata);
        end
        pulses(EXPLODE_LEN - 1, div);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL preempt_end: got start=%b busy=%b expected 0 0", start_audio, busy);
        end
        idle(5);
        n_checks++;
        if ({start_audio, busy, div} !== {2'b00, 32'd0}) begin
            n_fail++;
            $display("FAIL no_shoot_replay: got start=%b busy=%b div=%0d expected 0 0 0",
                     start_audio, busy, div);
        end
    endtask

    task automatic test_pending_shoot();
        int div, div2;
        cmd(16'h0002);
        idle(2);
        pulses(10, div);
        cmd(16'h0001);
        cmd(16'h0001);
        do_read(2'd0);
        n_checks++;
        if (readdata !== 16'h0007) begin
            n_fail++;
            $display("FAIL pend_read0: got %h expected 0007", readdata);
        end
        pulses(EXPLODE_LEN - 11, div2);
        div += div2;
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, selected_audio, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL pend_gap: got start=%b sel=%b busy=%b expected 0 0 1",
                     start_audio, selected_audio, busy);
        end
        idle(1);
        n_checks++;
        if ({start_audio, selected_audio} !== 2'b10) begin
            n_fail++;
            $display("FAIL pend_shoot_play: got start=%b sel=%b expected 1 0", start_audio, selected_audio);
        end
        pulses(SHOOT_LEN - 1, div2);
        div += div2;
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, busy, div} !== {2'b00, 32'd0}) begin
            n_fail++;
            $display("FAIL pend_end: got start=%b busy=%b div=%0d expected 0 0 0", start_audio, busy, div);
        end
    endtask

    task automatic test_both_and_saturate();
        int on_cycles;
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'(SHOOT_LEN)) begin
            n_fail++;
            $display("FAIL idle_count: got %0d expected %0d", readdata, SHOOT_LEN);
        end
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'(SHOOT_LEN)) begin
            n_fail++;
            $display("FAIL idle_pulses_ignored: got %0d expected %0d", readdata, SHOOT_LEN);
        end
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 16'h0003, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, selected_audio, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL both_gap: got start=%b sel=%b busy=%b expected 0 1 1",
                     start_audio, selected_audio, busy);
        end
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'd0) begin
            n_fail++;
            $display("FAIL gap_pulses_ignored: got %0d expected 0", readdata);
        end
        do_read(2'd2);
        n_checks++;
        if (readdata !== 16'(EXPLODE_LEN)) begin
            n_fail++;
            $display("FAIL len_explode: got %0d expected %0d", readdata, EXPLODE_LEN);
        end
        do_read(2'd0);
        n_checks++;
        if (readdata !== 16'h0007) begin
            n_fail++;
            $display("FAIL both_read0: got %h expected 0007", readdata);
        end
        repeat (EXPLODE_LEN) cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        n_checks++;
        if ({start_audio, selected_audio, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL both_to_shoot: got start=%b sel=%b busy=%b expected 0 0 1",
                     start_audio, selected_audio, busy);
        end
        idle(1);
        do_read(2'd2);
        n_checks++;
        if (readdata !== 16'(SHOOT_LEN)) begin
            n_fail++;
            $display("FAIL len_shoot: got %0d expected %0d", readdata, SHOOT_LEN);
        end
        on_cycles = 0;
        for (int i = 0; i < SHOOT_LEN + 20; i++) begin
            if (start_audio === 1'b1) on_cycles++;
            cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
        end
        n_checks++;
        if (on_cycles !== SHOOT_LEN) begin
            n_fail++;
            $display("FAIL sat_play_len: got %0d expected %0d", on_cycles, SHOOT_LEN);
        end
        do_read(2'd1);
        n_checks++;
        if ({readdata, busy} !== {16'(SHOOT_LEN), 1'b0}) begin
            n_fail++;
            $display("FAIL sat_count: got %0d busy=%b expected %0d busy=0", readdata, busy, SHOOT_LEN);
        end
    endtask

    task automatic test_reset_mid_play();
        int div;
        cmd(16'h0001);
        idle(2);
        pulses(50, div);
        cmd(16'h0002);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({start_audio, selected_audio, busy, readdata} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async: got start=%b sel=%b busy=%b rd=%h expected all 0",
                     start_audio, selected_audio, busy, readdata);
        end
        idle(2);
        reset = 1'b1;
        idle(4);
        n_checks++;
        if ({start_audio, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL pending_lost: got start=%b busy=%b expected 0 0", start_audio, busy);
        end
        do_read(2'd1);
        n_checks++;
        if (readdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", readdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            bit          cs, wr, rd, st;
            int          op;
            logic [1:0]  a;
            logic [15:0] wd;
            op = int'($urandom_range(0, 15));
            cs = ($urandom_range(0, 3) != 0);
            wr = (op == 0);
            rd = (op >= 1 && op <= 5);
            a  = 2'($urandom_range(0, 3));
            if (wr && $urandom_range(0, 1) == 0) a = 2'd0;
            wd = 16'($urandom);
            st = ($urandom_range(0, 1) == 1);
            cycle(cs, wr, rd, a, wd, st);
            n_checks++;
            if ({start_audio, selected_audio, busy, readdata} !== {m_play, m_sel, m_busy(), m_rd}) begin
                n_fail++;
                $display("FAIL random_%0d: got start=%b sel=%b busy=%b rd=%h expected %b %b %b %h",
                         i, start_audio, selected_audio, busy, readdata,
                         m_play, m_sel, m_busy(), m_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shoot_full();
        test_preempt();
        test_pending_shoot();
        test_both_and_saturate();
        test_reset_mid_play();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_effect_sequencer.md
Name: sound_effect_sequencer

Overview:
- Upstream control stage for the sound-effect tone generator.
- Accepts play commands from the HPS over an Avalon-MM slave.
- Arbitrates between shoot and explosion effects, then drives the tone generator's start/select pair.
- Counts consumed samples so each effect ends after exactly its ROM length and start is dropped cleanly between effects.

Parameters:
- SHOOT_LEN, 8105, number of samples in the shoot effect ROM
- EXPLODE_LEN, 3044, number of samples in the explosion effect ROM
- CNT_W, 14, width of the sample counter (must hold max(SHOOT_LEN, EXPLODE_LEN))

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- chipselect  in  1  Avalon-MM slave select
- write  in  1  Avalon-MM write strobe
- read  in  1  Avalon-MM read strobe
- address  in  2  register index
- writedata  in  16  Avalon-MM write data
- readdata  out  16  Avalon-MM read data, registered
- sample_taken  in  1  one-cycle pulse per sample accepted by the codec (left and right valid/ready both high)
- start_audio  out  1  tone generator run enable; low resets its ROM address counter
- selected_audio  out  1  0 = shoot, 1 = explosion; stable whenever start_audio = 1
- busy  out  1  high while an effect is playing or pending

Behaviour:
- Reset values (reset low, applied asynchronously):
  - All outputs 0; state IDLE; sample count 0; pending_shoot 0; pending_explode 0.
- Register map:
  - Write to address 0 (chipselect & write) is CMD: bit0 = request shoot, bit1 = request explosion. Writes with both bits 0 are ignored. Writes to addresses 1–3 are ignored.
  - Reads update readdata one cycle after chipselect & read:
    - addr 0 = {13'b0, pending_shoot, selected_audio, start_audio}
    - addr 1 = sample count, zero-extended
    - addr 2 = current effect length, SHOOT_LEN or EXPLODE_LEN per selected_audio
    - addr 3 = 0
- CMD write sets the pending flags the cycle after the write. If both bits are set, explosion wins and shoot is additionally left pending.
- States: IDLE, GAP, PLAY.
  - IDLE: start_audio = 0. If pending_explode, load selected_audio = 1 and clear pending_explode; else if pending_shoot, load selected_audio = 0 and clear pending_shoot. Either way go to GAP.
  - GAP: exactly one cycle with start_audio = 0, so the tone generator's counter clears. Count := 0. Next state is PLAY.
  - PLAY: start_audio = 1. Each sample_taken increments count. Leave when count reaches the effect length:
    - The cycle in which sample_taken makes count == length, start_audio deasserts on the next edge.
    - Go to IDLE if nothing is pending; otherwise go directly to GAP with the new selection applied.
- Preemption:
  - Explosion request during shoot PLAY aborts shoot: go to GAP next cycle with selected_audio = 1. The shoot is not resumed.
  - Explosion request during explosion PLAY restarts it via GAP.
  - Shoot request during explosion PLAY sets pending_shoot only (one-deep; repeated requests collapse).
  - Shoot request during shoot PLAY restarts shoot via GAP.
- selected_audio changes only on entry to GAP, never while start_audio = 1.
- sample_taken is ignored outside PLAY. Count saturates at the length and never wraps.
- busy = (state != IDLE) | pending_shoot | pending_explode.
- If reset is asserted mid-effect, start_audio drops immediately (asynchronously) and all pending requests are lost.
- Latency:
  - CMD write at cycle N → pending set at N+1 → GAP at N+2 → start_audio = 1 at N+3.
  - During PLAY, a preempting write at N → GAP at N+2.

Test Plan:
- Reset low for 3 cycles, then release → readdata = 0, start_audio = 0, busy = 0. Assert reset mid-PLAY → start_audio = 0 in the same cycle.
- Write CMD = 0x0001, then issue 8105 sample_taken pulses → start_audio rises 3 cycles after the write with selected_audio = 0, falls the cycle after the 8105th pulse, busy = 0.
- Write 0x0001, issue 100 pulses, then write 0x0002 → one GAP cycle with start_audio = 0, then selected_audio = 1 and count = 0. After 3044 pulses the block returns to IDLE and no shoot replays.
- Write 0x0002, issue 10 pulses, write 0x0001 twice → addr 0 read shows bit2 = 1. After 3044 pulses: GAP, then one shoot of 8105 samples, then IDLE.
- Write 0x0003 from IDLE → explosion plays first, then shoot. Extra sample_taken pulses in IDLE/GAP do not change addr 1.
- Read addr 2 while each effect plays → 3044 for explosion, 8105 for shoot. Pulse sample_taken continuously → count stops at the length and never exceeds it.
